// File: rtl/multicycle_control_if.sv
// Handshake bundle between the multicycle datapath and its control FSM.
// master = datapath/bench side, slave = multicycle_control.
interface multicycle_control_if;
  logic [5:0] opcode_i;
  logic       zero_i;
  logic       mem_ready_i;
  logic       pc_write_o;
  logic       ir_write_o;
  logic       reg_write_o;
  logic       mem_read_o;
  logic       mem_write_o;
  logic       i_or_d_o;
  logic       reg_dst_o;
  logic       mem_to_reg_o;
  logic       alu_src_a_o;
  logic [1:0] alu_src_b_o;
  logic [2:0] alu_op_o;
  logic [1:0] pc_src_o;
  logic       retire_o;
  logic [3:0] state_o;
  logic       err_o;

  modport master (
    output opcode_i, zero_i, mem_ready_i,
    input  pc_write_o, ir_write_o, reg_write_o, mem_read_o, mem_write_o,
           i_or_d_o, reg_dst_o, mem_to_reg_o, alu_src_a_o, alu_src_b_o,
           alu_op_o, pc_src_o, retire_o, state_o, err_o
  );

  modport slave (
    input  opcode_i, zero_i, mem_ready_i,
    output pc_write_o, ir_write_o, reg_write_o, mem_read_o, mem_write_o,
           i_or_d_o, reg_dst_o, mem_to_reg_o, alu_src_a_o, alu_src_b_o,
           alu_op_o, pc_src_o, retire_o, state_o, err_o
  );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle MIPS-subset control FSM with memory-wait watchdog and sticky error.
// Optional macro JUMP_INSTR_EN enables the J instruction (opcode 0x02).
module multicycle_control #(
  parameter int WATCHDOG_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  multicycle_control_if.slave  bus
);

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADDR  = 4'd2,
    MEM_READ  = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WRITE = 4'd5,
    R_EXEC    = 4'd6,
    R_WB      = 4'd7,
    BRANCH    = 4'd8,
    I_EXEC    = 4'd9,
    I_WB      = 4'd10,
    JUMP      = 4'd11
  } state_t;

  localparam logic [7:0] WD_LAST = 8'(WATCHDOG_CYCLES - 1);

  state_t     state;
  state_t     state_d;
  logic [7:0] wd_cnt;
  logic       err_q;
  logic       wait_st;
  logic       wd_abort;
  logic       err_set;

  logic       pc_write;
  logic       ir_write;
  logic       reg_write;
  logic       mem_read;
  logic       mem_write;
  logic       i_or_d;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_op;
  logic [1:0] pc_src;
  logic       retire;

  // A ready memory always wins over the watchdog in the same cycle.
  assign wait_st  = (state == FETCH) || (state == MEM_READ) || (state == MEM_WRITE);
  assign wd_abort = wait_st && !bus.mem_ready_i && (wd_cnt == WD_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= FETCH;
    end else begin
      state <= state_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wd_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      if (wait_st && !bus.mem_ready_i) begin
        wd_cnt <= wd_abort ? '0 : wd_cnt + 8'd1;
      end else begin
        wd_cnt <= '0;
      end
      if (err_set) begin
        err_q <= 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state;
    err_set = wd_abort;
    case (state)
      FETCH: begin
        if (bus.mem_ready_i)  state_d = DECODE;
        else if (wd_abort)    state_d = FETCH;
      end
      DECODE: begin
        case (bus.opcode_i)
          6'h00:        state_d = R_EXEC;
          6'h23, 6'h2B: state_d = MEM_ADDR;
          6'h04, 6'h05: state_d = BRANCH;
          6'h08, 6'h0D: state_d = I_EXEC;
`ifdef JUMP_INSTR_EN
          6'h02:        state_d = JUMP;
`endif
          default: begin
            state_d = FETCH;
            err_set = 1'b1;
          end
        endcase
      end
      MEM_ADDR:  state_d = (bus.opcode_i == 6'h23) ? MEM_READ : MEM_WRITE;
      MEM_READ: begin
        if (bus.mem_ready_i)  state_d = MEM_WB;
        else if (wd_abort)    state_d = FETCH;
      end
      MEM_WRITE: begin
        if (bus.mem_ready_i || wd_abort) state_d = FETCH;
      end
      R_EXEC:    state_d = R_WB;
      I_EXEC:    state_d = I_WB;
      default:   state_d = FETCH;
    endcase
  end

  always_comb begin
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    i_or_d     = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 3'b000;
    pc_src     = 2'b00;
    retire     = 1'b0;
    case (state)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        pc_write  = bus.mem_ready_i;
        ir_write  = bus.mem_ready_i;
      end
      DECODE:    alu_src_b = 2'b11;
      MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      MEM_READ: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
      end
      MEM_WRITE: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        retire    = bus.mem_ready_i;
      end
      R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 3'b010;
      end
      R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        retire    = 1'b1;
      end
      BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = 3'b001;
        pc_src    = 2'b01;
        retire    = 1'b1;
        pc_write  = ((bus.opcode_i == 6'h04) &&  bus.zero_i) ||
                    ((bus.opcode_i == 6'h05) && !bus.zero_i);
      end
      I_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = (bus.opcode_i == 6'h0D) ? 3'b011 : 3'b000;
      end
      I_WB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
      end
`ifdef JUMP_INSTR_EN
      JUMP: begin
        pc_write = 1'b1;
        pc_src   = 2'b10;
        retire   = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  // Write strobes are gated by reset so an abandoned instruction cannot write.
  assign bus.pc_write_o   = pc_write  & reset;
  assign bus.ir_write_o   = ir_write  & reset;
  assign bus.reg_write_o  = reg_write & reset;
  assign bus.mem_write_o  = mem_write & reset;
  assign bus.retire_o     = retire    & reset;
  assign bus.mem_read_o   = mem_read;
  assign bus.i_or_d_o     = i_or_d;
  assign bus.reg_dst_o    = reg_dst;
  assign bus.mem_to_reg_o = mem_to_reg;
  assign bus.alu_src_a_o  = alu_src_a;
  assign bus.alu_src_b_o  = alu_src_b;
  assign bus.alu_op_o     = alu_op;
  assign bus.pc_src_o     = pc_src;
  assign bus.state_o      = state;
  assign bus.err_o        = err_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench for multicycle_control: per-instruction expected state/output
// traces are built from the instruction class rules and compared every cycle.
module tb_multicycle_control;

  localparam int WD = 16;

  typedef struct {
    logic [3:0] st;
    logic       rdy;
    logic       set_err;
  } ent_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;
  logic err_exp = 1'b0;
  ent_t q[$];

  multicycle_control_if bus ();

  multicycle_control #(.WATCHDOG_CYCLES(WD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // {pc_write, ir_write, reg_write, mem_read, mem_write, i_or_d, reg_dst,
  //  mem_to_reg, alu_src_a, alu_src_b[2], alu_op[3], pc_src[2], retire}
  function automatic logic [16:0] got_vec();
    return {bus.pc_write_o, bus.ir_write_o, bus.reg_write_o, bus.mem_read_o,
            bus.mem_write_o, bus.i_or_d_o, bus.reg_dst_o, bus.mem_to_reg_o,
            bus.alu_src_a_o, bus.alu_src_b_o, bus.alu_op_o, bus.pc_src_o,
            bus.retire_o};
  endfunction

  function automatic logic [16:0] exp_out(input logic [3:0] st, input logic [5:0] op,
                                          input logic z, input logic rdy);
    logic pw, iw, rw, mr, mw, iod, rd, m2r, a, ret;
    logic [1:0] b, ps;
    logic [2:0] alu;
    {pw, iw, rw, mr, mw, iod, rd, m2r, a, ret} = '0;
    b = 2'b00; ps = 2'b00; alu = 3'b000;
    case (st)
      4'd0:  begin mr = 1; b = 2'b01; pw = rdy; iw = rdy; end
      4'd1:  b = 2'b11;
      4'd2:  begin a = 1; b = 2'b10; end
      4'd3:  begin mr = 1; iod = 1; end
      4'd4:  begin rw = 1; m2r = 1; ret = 1; end
      4'd5:  begin mw = 1; iod = 1; ret = rdy; end
      4'd6:  begin a = 1; alu = 3'b010; end
      4'd7:  begin rw = 1; rd = 1; ret = 1; end
      4'd8:  begin a = 1; alu = 3'b001; ps = 2'b01; ret = 1;
                   pw = (op == 6'h04 && z) || (op == 6'h05 && !z); end
      4'd9:  begin a = 1; b = 2'b10; alu = (op == 6'h0D) ? 3'b011 : 3'b000; end
      4'd10: begin rw = 1; ret = 1; end
      4'd11: begin pw = 1; ps = 2'b10; ret = 1; end
      default: ;
    endcase
    return {pw, iw, rw, mr, mw, iod, rd, m2r, a, b, alu, ps, ret};
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  // n low-ready cycles then a ready one; n >= WD means the watchdog fires.
  task automatic push_wait(input logic [3:0] st, input int n, output bit aborted);
    if (n >= WD) begin
      for (int i = 0; i < WD; i++) q.push_back('{st, 1'b0, (i == WD - 1)});
      aborted = 1;
    end else begin
      for (int i = 0; i < n; i++) q.push_back('{st, 1'b0, 1'b0});
      q.push_back('{st, 1'b1, 1'b0});
      aborted = 0;
    end
  endtask

  task automatic build_instr(input logic [5:0] op, input int fw, input int mw);
    bit ab;
    q.delete();
    push_wait(4'd0, fw, ab);
    if (ab) return;
    q.push_back('{4'd1, rbit(), 1'b0});
    case (op)
      6'h00: begin q.push_back('{4'd6, rbit(), 1'b0}); q.push_back('{4'd7, rbit(), 1'b0}); end
      6'h23: begin
        q.push_back('{4'd2, rbit(), 1'b0});
        push_wait(4'd3, mw, ab);
        if (!ab) q.push_back('{4'd4, rbit(), 1'b0});
      end
      6'h2B: begin q.push_back('{4'd2, rbit(), 1'b0}); push_wait(4'd5, mw, ab); end
      6'h04, 6'h05: q.push_back('{4'd8, rbit(), 1'b0});
      6'h08, 6'h0D: begin q.push_back('{4'd9, rbit(), 1'b0}); q.push_back('{4'd10, rbit(), 1'b0}); end
`ifdef JUMP_INSTR_EN
      6'h02: q.push_back('{4'd11, rbit(), 1'b0});
`endif
      default: q[q.size() - 1].set_err = 1'b1;
    endcase
  endtask

  task automatic step(input ent_t e);
    bus.mem_ready_i = e.rdy;
    #1;
    chk($sformatf("state op=%0h", bus.opcode_i), 32'(bus.state_o), 32'(e.st));
    chk($sformatf("outs st=%0d op=%0h", e.st, bus.opcode_i), 32'(got_vec()),
        32'(exp_out(e.st, bus.opcode_i, bus.zero_i, e.rdy)));
    chk("err", 32'(bus.err_o), 32'(err_exp));
    if (e.set_err) err_exp = 1'b1;
    @(negedge clk);
  endtask

  task automatic do_instr(input logic [5:0] op, input logic z, input int fw, input int mw);
    bus.opcode_i = op;
    bus.zero_i   = z;
    build_instr(op, fw, mw);
    foreach (q[i]) step(q[i]);
  endtask

  function automatic int pick_wait();
    int r;
    r = int'($urandom_range(0, 9));
    if (r == 0) return WD;
    if (r == 1) return WD - 1;
    return int'($urandom_range(0, 3));
  endfunction

  logic [5:0] op_tab [10];

  initial begin
    op_tab = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h08, 6'h0D, 6'h02, 6'h3F, 6'h00};
    bus.opcode_i    = 6'h00;
    bus.zero_i      = 1'b0;
    bus.mem_ready_i = 1'b1;
    #2 reset = 1'b0;
    #1;
    chk("rst_state", 32'(bus.state_o), 32'd0);
    chk("rst_err", 32'(bus.err_o), 32'd0);
    chk("rst_strobes", 32'({bus.pc_write_o, bus.ir_write_o, bus.reg_write_o,
                            bus.mem_write_o, bus.retire_o}), 32'd0);
    repeat (3) @(negedge clk);
    chk("rst_hold_state", 32'(bus.state_o), 32'd0);
    reset = 1'b1;

    do_instr(6'h00, 1'b0, 0, 0);
    do_instr(6'h23, 1'b0, 0, 3);
    do_instr(6'h05, 1'b0, 1, 0);
    do_instr(6'h05, 1'b1, 0, 0);
    do_instr(6'h04, 1'b0, 0, 0);
    do_instr(6'h04, 1'b1, 2, 0);
    do_instr(6'h08, 1'b0, 0, 0);
    do_instr(6'h0D, 1'b1, 0, 0);
    do_instr(6'h2B, 1'b0, 0, 2);
    do_instr(6'h23, 1'b0, WD - 1, WD - 1);
    do_instr(6'h00, 1'b0, WD, 0);
    do_instr(6'h23, 1'b0, 0, WD);
    do_instr(6'h2B, 1'b0, 0, WD);
    do_instr(6'h02, 1'b0, 0, 0);
    do_instr(6'h3F, 1'b0, 0, 0);

    for (int k = 0; k < 150; k++) begin
      logic [5:0] op;
      int sel;
      sel = int'($urandom_range(0, 10));
      op  = (sel == 10) ? 6'($urandom) : op_tab[sel];
      do_instr(op, rbit(), pick_wait(), pick_wait());
    end

    // Reset in the middle of a store must kill the write strobe at once.
    bus.opcode_i = 6'h2B;
    bus.zero_i   = 1'b0;
    build_instr(6'h2B, 0, 5);
    for (int i = 0; i < 4; i++) step(q[i]);
    bus.mem_ready_i = 1'b0;
    #1;
    chk("mw_before_rst", 32'(bus.mem_write_o), 32'd1);
    chk("err_before_rst", 32'(bus.err_o), 32'd1);
    reset = 1'b0;
    #1;
    chk("mw_after_rst", 32'(bus.mem_write_o), 32'd0);
    chk("state_after_rst", 32'(bus.state_o), 32'd0);
    chk("err_after_rst", 32'(bus.err_o), 32'd0);
    err_exp = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    do_instr(6'h00, 1'b0, 0, 0);
    do_instr(6'h23, 1'b0, 1, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
